// File: rtl/hamming74_nibble_packer.sv
// Pairs decoded Hamming(7,4) nibbles into bytes and queues them in a FWFT FIFO; 1-cycle pair-to-output latency, o_ready drops only when the FIFO is full.
// Frame-start marker realigns pairing. Optional macro HAMMING74_PACK_PAR_EN adds per-entry even parity on o_parity.
module hamming74_nibble_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter bit LOW_FIRST  = 1'b1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [8:0]                   i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [7:0]                   o_byte,
    output logic                         o_sof,
    output logic                         o_orphan,
`ifdef HAMMING74_PACK_PAR_EN
    output logic                         o_parity,
`endif
    output logic [$clog2(FIFO_DEPTH):0]  o_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
`ifdef HAMMING74_PACK_PAR_EN
    localparam int EW = 10;
`else
    localparam int EW = 9;
`endif
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_hold;
    logic            r_sof_pend;
    logic            r_orphan;
    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic            w_hold_ld;
    logic            w_sof_pend_nxt;
    logic            w_orphan_nxt;
    logic [3:0]      w_nib;
    logic            w_marker;
    logic [7:0]      w_byte;
    logic [EW-1:0]   w_entry;
    logic [EW-1:0]   w_head;
    logic            w_unused_hi;

    assign w_nib       = i_data[3:0];
    assign w_marker    = i_data[8];
    assign w_unused_hi = ^i_data[7:4];

    // Readiness depends only on occupancy, so a full FIFO stalls even the first nibble of a pair.
    assign o_ready  = (r_count != DEPTH_C);
    assign o_valid  = (r_count != '0);
    assign w_accept = i_valid & o_ready;
    assign w_pop    = o_valid & i_ready;

    assign w_byte = LOW_FIRST ? {w_nib, r_hold} : {r_hold, w_nib};

`ifdef HAMMING74_PACK_PAR_EN
    assign w_entry = {^w_byte, r_sof_pend, w_byte};
`else
    assign w_entry = {r_sof_pend, w_byte};
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_push         = 1'b0;
        w_hold_ld      = 1'b0;
        w_sof_pend_nxt = r_sof_pend;
        w_orphan_nxt   = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_hold_ld      = 1'b1;
                    w_sof_pend_nxt = w_marker;
                    w_state_nxt    = S_HALF;
                end
            end
            S_HALF: begin
                if (w_accept) begin
                    if (w_marker) begin
                        // New frame starts mid-pair: drop the stale half and restart pairing.
                        w_orphan_nxt   = 1'b1;
                        w_hold_ld      = 1'b1;
                        w_sof_pend_nxt = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = S_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_EMPTY;
            r_hold     <= '0;
            r_sof_pend <= 1'b0;
            r_orphan   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sof_pend <= w_sof_pend_nxt;
            r_orphan   <= w_orphan_nxt;
            if (w_hold_ld) begin
                r_hold <= w_nib;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign o_byte   = w_head[7:0];
    assign o_sof    = w_head[8];
`ifdef HAMMING74_PACK_PAR_EN
    assign o_parity = w_head[9];
`endif
    assign o_orphan = r_orphan;
    assign o_count  = r_count;

endmodule

// File: tb/tb_hamming74_nibble_packer.sv
// Scoreboard bench: stimulus queues hand-computed {sof, byte} expectations, a negedge monitor checks every pop.
module tb_hamming74_nibble_packer;

    localparam int D = 4;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [8:0] i_data;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_byte;
    logic       o_sof;
    logic       o_orphan;
`ifdef HAMMING74_PACK_PAR_EN
    logic       o_parity;
`endif
    logic [$clog2(D):0] o_count;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb [$];
    logic [8:0] mon_e;

    hamming74_nibble_packer #(.FIFO_DEPTH(D), .LOW_FIRST(1'b1)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_byte   (o_byte),
        .o_sof    (o_sof),
        .o_orphan (o_orphan),
`ifdef HAMMING74_PACK_PAR_EN
        .o_parity (o_parity),
`endif
        .o_count  (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got byte %0h with empty scoreboard at %0t", o_byte, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_byte", {24'd0, o_byte}, {24'd0, mon_e[7:0]});
                chk("pop_sof", {31'd0, o_sof}, {31'd0, mon_e[8]});
`ifdef HAMMING74_PACK_PAR_EN
                chk("pop_parity", {31'd0, o_parity}, {31'd0, ^mon_e[7:0]});
`endif
            end
        end
    end

    // Offers one nibble and returns 1 time unit after the clock edge that accepted it.
    task automatic send(input logic m, input logic [3:0] n);
        int t;
        i_valid = 1'b1;
        i_data  = {m, ~n, n};
        t = 0;
        @(negedge i_clk);
        while (!o_ready && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: o_ready stuck at 0, nibble %0h", n);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || o_count != 0) && t < 200) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_count", {29'd0, o_count}, 0);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        #12;
        chk("rst_valid",  {31'd0, o_valid}, 0);
        chk("rst_byte",   {24'd0, o_byte}, 0);
        chk("rst_sof",    {31'd0, o_sof}, 0);
        chk("rst_orphan", {31'd0, o_orphan}, 0);
        chk("rst_count",  {29'd0, o_count}, 0);
        chk("rst_ready",  {31'd0, o_ready}, 1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Basic pair with latency check
        i_ready = 1'b1;
        send(1'b1, 4'h5);
        chk("half_no_valid", {31'd0, o_valid}, 0);
        sb.push_back({1'b1, 8'hA5});
        send(1'b0, 4'hA);
        chk("t1_valid", {31'd0, o_valid}, 1);
        chk("t1_count", {29'd0, o_count}, 1);
        wait_drain();

        // Two bytes in one frame
        sb.push_back({1'b1, 8'hC3});
        sb.push_back({1'b0, 8'h21});
        send(1'b1, 4'h3);
        send(1'b0, 4'hC);
        send(1'b0, 4'h1);
        send(1'b0, 4'h2);
        wait_drain();

        // Orphaned half byte
        sb.push_back({1'b1, 8'h49});
        send(1'b1, 4'h7);
        chk("orphan_idle", {31'd0, o_orphan}, 0);
        send(1'b1, 4'h9);
        chk("orphan_pulse", {31'd0, o_orphan}, 1);
        @(posedge i_clk);
        #1;
        chk("orphan_clear", {31'd0, o_orphan}, 0);
        send(1'b0, 4'h4);
        wait_drain();

        // Fill to full with consumer stalled
        i_ready = 1'b0;
        sb.push_back({1'b1, 8'h21});
        sb.push_back({1'b0, 8'h43});
        sb.push_back({1'b0, 8'h65});
        sb.push_back({1'b0, 8'h87});
        for (int k = 0; k < 2 * D; k++) begin
            send(k == 0, 4'(k + 1));
        end
        chk("full_count", {29'd0, o_count}, D);
        chk("full_ready", {31'd0, o_ready}, 0);
        i_valid = 1'b1;
        i_data  = {1'b0, 4'h0, 4'hF};
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("full_ignore_ready", {31'd0, o_ready}, 0);
            chk("full_ignore_count", {29'd0, o_count}, D);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("after_pop_ready", {31'd0, o_ready}, 1);
        chk("after_pop_count", {29'd0, o_count}, D - 1);
        wait_drain();

        // Simultaneous push and pop at count 2, across pointer wrap
        i_ready = 1'b0;
        sb.push_back({1'b1, 8'hE1});
        sb.push_back({1'b0, 8'hD2});
        send(1'b1, 4'h1);
        send(1'b0, 4'hE);
        send(1'b0, 4'h2);
        send(1'b0, 4'hD);
        chk("pp_pre_count", {29'd0, o_count}, 2);
        for (int k = 0; k < 2; k++) begin
            send(1'b0, 4'(3 + k));
            sb.push_back({1'b0, (k == 0) ? 8'hC3 : 8'hB4});
            i_ready = 1'b1;
            i_valid = 1'b1;
            i_data  = {1'b0, 4'h5, 4'(12 - k)};
            @(posedge i_clk);
            #1;
            i_ready = 1'b0;
            i_valid = 1'b0;
            chk("pp_count", {29'd0, o_count}, 2);
        end
        i_ready = 1'b1;
        wait_drain();

        // Asynchronous reset mid-operation
        i_ready = 1'b0;
        send(1'b1, 4'h1);
        send(1'b0, 4'h2);
        send(1'b0, 4'h3);
        send(1'b0, 4'h4);
        send(1'b0, 4'h5);
        send(1'b0, 4'h6);
        send(1'b0, 4'h7);
        chk("pre_rst_count", {29'd0, o_count}, 3);
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_valid",  {31'd0, o_valid}, 0);
        chk("arst_count",  {29'd0, o_count}, 0);
        chk("arst_orphan", {31'd0, o_orphan}, 0);
        sb.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("post_rst_orphan", {31'd0, o_orphan}, 0);
        i_ready = 1'b1;
        sb.push_back({1'b0, 8'hB6});
        send(1'b0, 4'h6);
        chk("post_rst_half", {31'd0, o_valid}, 0);
        send(1'b0, 4'hB);
        chk("post_rst_valid", {31'd0, o_valid}, 1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
